// File: rtl/divider_rr_scheduler.sv
// divider_rr_scheduler: round-robin sharing of one fixed-latency divider among CH_NUM channels
// Ports:
//   clk_i, rst_n_i               clock, asynchronous active-low reset
//   issue_en_i                   0 holds all grants; in-flight results still drain
//   req_valid_i/req_dividend_i   per-channel requests (channel k at [k*DIVIDEND_W +: DIVIDEND_W])
//   req_ready_o                  combinational one-hot grant
//   div_valid_o/div_dividend_o   registered issue to the divider
//   div_valid_i/div_quotient_i   divider result
//   res_valid_o/res_ch_o/res_quotient_o  registered result tagged with its channel id
//   busy_o                       any issue in flight
//   err_o                        sticky: divider valid disagreed with the tag pipe
module divider_rr_scheduler #(
  parameter int CH_NUM = 4,
  parameter int DIVIDEND_W = 16,
  parameter int QUOTIENT_W = 12,
  parameter int DIV_LATENCY = 2,
  localparam int CH_ID_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         issue_en_i,
  input  logic [CH_NUM-1:0]            req_valid_i,
  input  logic [CH_NUM*DIVIDEND_W-1:0] req_dividend_i,
  output logic [CH_NUM-1:0]            req_ready_o,
  output logic                         div_valid_o,
  output logic [DIVIDEND_W-1:0]        div_dividend_o,
  input  logic                         div_valid_i,
  input  logic [QUOTIENT_W-1:0]        div_quotient_i,
  output logic                         res_valid_o,
  output logic [CH_ID_W-1:0]           res_ch_o,
  output logic [QUOTIENT_W-1:0]        res_quotient_o,
  output logic                         busy_o,
  output logic                         err_o
);
  logic [CH_ID_W-1:0] ptr, gnt_ch, iss_ch;
  logic grant;
  logic [DIV_LATENCY-1:0] tag_v;
  logic [CH_ID_W-1:0] tag_ch [DIV_LATENCY];
  logic tail_hit;
  // Scan from ptr upward with wrap; the first requester wins. Grants are
  // suppressed while reset is asserted so every output reads 0 in reset.
  always_comb begin
    grant = 1'b0;
    gnt_ch = '0;
    req_ready_o = '0;
    for (int i = 0; i < CH_NUM; i++)
      if (!grant && issue_en_i && rst_n_i && req_valid_i[(int'(ptr) + i) % CH_NUM]) begin
        grant = 1'b1;
        gnt_ch = CH_ID_W'((int'(ptr) + i) % CH_NUM);
      end
    if (grant) req_ready_o[gnt_ch] = 1'b1;
  end
  assign tail_hit = div_valid_i & tag_v[DIV_LATENCY-1];
  assign busy_o = div_valid_o | (|tag_v);
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      ptr <= '0;
      div_valid_o <= 1'b0;
      div_dividend_o <= '0;
      iss_ch <= '0;
      tag_v <= '0;
      tag_ch <= '{default: '0};
      res_valid_o <= 1'b0;
      res_ch_o <= '0;
      res_quotient_o <= '0;
      err_o <= 1'b0;
    end else begin
      div_valid_o <= grant;
      if (grant) begin
        ptr <= (gnt_ch == CH_ID_W'(CH_NUM - 1)) ? '0 : gnt_ch + 1'b1;
        div_dividend_o <= req_dividend_i[gnt_ch*DIVIDEND_W +: DIVIDEND_W];
        iss_ch <= gnt_ch;
      end
      // Tag pipe is sized so its tail lines up with the divider's valid-out.
      tag_v[0] <= div_valid_o;
      tag_ch[0] <= iss_ch;
      for (int i = 1; i < DIV_LATENCY; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_ch[i] <= tag_ch[i-1];
      end
      res_valid_o <= tail_hit;
      if (tail_hit) begin
        res_ch_o <= tag_ch[DIV_LATENCY-1];
        res_quotient_o <= div_quotient_i;
      end
      if (div_valid_i != tag_v[DIV_LATENCY-1]) err_o <= 1'b1;
    end
endmodule

// File: tb/tb_divider_rr_scheduler.sv
// tb_divider_rr_scheduler: scoreboard bench for the round-robin divider scheduler
module tb_divider_rr_scheduler;
  localparam int CH_NUM = 4, DW = 16, QW = 12, L = 2, IDW = 2;
  logic clk = 1'b0, rst_n = 1'b0, issue_en = 1'b0;
  logic [CH_NUM-1:0] req_valid = '0;
  logic [DW-1:0] dvd [CH_NUM] = '{default: '0};
  logic [CH_NUM*DW-1:0] req_dividend;
  logic [CH_NUM-1:0] req_ready;
  logic div_valid_o, div_valid_in, res_valid_o, busy_o, err_o;
  logic [DW-1:0] div_dividend_o;
  logic [QW-1:0] div_quot, res_quotient_o;
  logic [IDW-1:0] res_ch_o;
  logic [L-1:0] dp_v = '0;
  logic [QW-1:0] dp_q [L];
  typedef struct { int due; int ch; int q; } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0, cyc = 0, ptr = 0, prev_g = -1, max_wait = 0;
  logic [DW-1:0] prev_d = '0;
  int wait_c [CH_NUM] = '{default: 0};

  always #5 clk = ~clk;

  always_comb begin
    req_dividend = '0;
    for (int k = 0; k < CH_NUM; k++) req_dividend[k*DW +: DW] = dvd[k];
  end

  // Divider stand-in: divide by 9, fixed latency L, never reset.
  always @(posedge clk) begin
    dp_v <= {dp_v[L-2:0], div_valid_o};
    dp_q[0] <= QW'(div_dividend_o / 9);
    dp_q[1] <= dp_q[0];
  end
  assign div_valid_in = dp_v[L-1];
  assign div_quot = dp_q[L-1];

  divider_rr_scheduler #(.CH_NUM(CH_NUM), .DIVIDEND_W(DW), .QUOTIENT_W(QW), .DIV_LATENCY(L)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .issue_en_i(issue_en),
    .req_valid_i(req_valid), .req_dividend_i(req_dividend), .req_ready_o(req_ready),
    .div_valid_o(div_valid_o), .div_dividend_o(div_dividend_o),
    .div_valid_i(div_valid_in), .div_quotient_i(div_quot),
    .res_valid_o(res_valid_o), .res_ch_o(res_ch_o), .res_quotient_o(res_quotient_o),
    .busy_o(busy_o), .err_o(err_o));

  task automatic clear_model();
    sb.delete();
    ptr = 0;
    prev_g = -1;
    for (int k = 0; k < CH_NUM; k++) wait_c[k] = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = '0;
    issue_en = 1'b0;
    repeat (L + 3) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_model();
  endtask

  // One clock: compare against the model at negedge, then advance.
  task automatic step(output int g);
    logic [CH_NUM-1:0] er;
    logic eb;
    @(negedge clk);
    g = -1;
    er = '0;
    if (issue_en)
      for (int i = 0; i < CH_NUM; i++)
        if (g < 0 && req_valid[(ptr + i) % CH_NUM]) g = (ptr + i) % CH_NUM;
    if (g >= 0) er[g] = 1'b1;
    checks++;
    if (req_ready !== er) begin
      errors++;
      $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, req_ready, er);
    end
    checks++;
    if (div_valid_o !== (prev_g >= 0) || (prev_g >= 0 && div_dividend_o !== prev_d)) begin
      errors++;
      $display("FAIL issue cyc=%0d got v=%b d=%0d exp v=%b d=%0d", cyc, div_valid_o, div_dividend_o, prev_g >= 0, prev_d);
    end
    checks++;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      if (res_valid_o !== 1'b1 || res_ch_o !== IDW'(sb[0].ch) || res_quotient_o !== QW'(sb[0].q)) begin
        errors++;
        $display("FAIL result cyc=%0d got v=%b ch=%0d q=%0d exp v=1 ch=%0d q=%0d", cyc, res_valid_o, res_ch_o, res_quotient_o, sb[0].ch, sb[0].q);
      end
      void'(sb.pop_front());
    end else if (res_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL no_result cyc=%0d got res_valid=%b exp 0", cyc, res_valid_o);
    end
    eb = (prev_g >= 0);
    foreach (sb[j]) if (cyc >= sb[j].due - L - 1 && cyc < sb[j].due) eb = 1'b1;
    checks++;
    if (busy_o !== eb) begin
      errors++;
      $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy_o, eb);
    end
    for (int k = 0; k < CH_NUM; k++)
      if (req_ready[k]) begin
        if (wait_c[k] > max_wait) max_wait = wait_c[k];
        wait_c[k] = 0;
      end else if (issue_en && req_valid[k]) wait_c[k]++;
    if (g >= 0) begin
      sb.push_back('{cyc + L + 2, g, int'(dvd[g] / 9) % 4096});
      ptr = (g + 1) % CH_NUM;
      prev_d = dvd[g];
    end
    prev_g = g;
    @(posedge clk);
    cyc++;
    #1;
    if (g >= 0) req_valid[g] = 1'b0;
  endtask

  task automatic drain();
    int g;
    req_valid = '0;
    repeat (L + 3) step(g);
  endtask

  task automatic test_reset();
    req_valid = '1;
    issue_en = 1'b1;
    #3;
    checks++;
    if (req_ready !== '0 || div_valid_o !== 1'b0 || div_dividend_o !== '0) begin
      errors++;
      $display("FAIL reset_issue got rdy=%b v=%b d=%0d exp 0", req_ready, div_valid_o, div_dividend_o);
    end
    checks++;
    if (res_valid_o !== 1'b0 || res_ch_o !== '0 || res_quotient_o !== '0) begin
      errors++;
      $display("FAIL reset_result got v=%b ch=%0d q=%0d exp 0", res_valid_o, res_ch_o, res_quotient_o);
    end
    checks++;
    if (busy_o !== 1'b0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_status got busy=%b err=%b exp 0", busy_o, err_o);
    end
    apply_reset();
  endtask

  task automatic test_single();
    int g;
    issue_en = 1'b1;
    dvd[2] = 16'd900;
    req_valid = 4'b0100;
    step(g);
    repeat (L + 3) step(g);
    checks++;
    if (res_ch_o !== IDW'(2) || res_quotient_o !== QW'(100)) begin
      errors++;
      $display("FAIL single_hold got ch=%0d q=%0d exp ch=2 q=100", res_ch_o, res_quotient_o);
    end
  endtask

  task automatic test_round_robin();
    int g;
    apply_reset();
    issue_en = 1'b1;
    for (int k = 0; k < CH_NUM; k++) dvd[k] = DW'($urandom_range(0, 36000));
    req_valid = '1;
    repeat (12) begin
      step(g);
      if (g >= 0) begin
        req_valid[g] = 1'b1;
        dvd[g] = DW'($urandom_range(0, 36000));
      end
    end
    drain();
  endtask

  task automatic test_pair();
    int g;
    max_wait = 0;
    issue_en = 1'b1;
    dvd[1] = 16'd45;
    req_valid = 4'b0010;
    step(g);
    dvd[1] = 16'd1800;
    dvd[3] = 16'd2700;
    req_valid = 4'b1010;
    repeat (8) begin
      step(g);
      if (g >= 0) begin
        req_valid[g] = 1'b1;
        dvd[g] = DW'($urandom_range(0, 36000));
      end
    end
    drain();
    checks++;
    if (max_wait > CH_NUM - 1) begin
      errors++;
      $display("FAIL pair_fairness got max_wait=%0d exp <=%0d", max_wait, CH_NUM - 1);
    end
  endtask

  task automatic test_issue_en();
    int g;
    issue_en = 1'b1;
    dvd[0] = 16'd333;
    req_valid = 4'b0001;
    step(g);
    issue_en = 1'b0;
    for (int k = 1; k < CH_NUM; k++) dvd[k] = DW'(k * 999);
    req_valid = 4'b1110;
    repeat (5) step(g);
    issue_en = 1'b1;
    repeat (3) step(g);
    drain();
  endtask

  task automatic test_reset_mid();
    int g;
    issue_en = 1'b1;
    dvd[0] = 16'd81;
    dvd[1] = 16'd90;
    req_valid = 4'b0011;
    step(g);
    step(g);
    rst_n = 1'b0;
    req_valid = '1;
    #1;
    checks++;
    if (div_valid_o !== 1'b0 || req_ready !== '0 || busy_o !== 1'b0 || res_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset_zero got v=%b rdy=%b busy=%b res=%b exp 0", div_valid_o, req_ready, busy_o, res_valid_o);
    end
    req_valid = '0;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(g);
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL late_err got=%b exp=1", err_o);
    end
    repeat (2) step(g);
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky got=%b exp=1", err_o);
    end
    apply_reset();
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got=%b exp=0", err_o);
    end
  endtask

  task automatic test_random();
    int g;
    apply_reset();
    max_wait = 0;
    repeat (10000) begin
      issue_en = ($urandom_range(0, 9) != 0);
      for (int k = 0; k < CH_NUM; k++)
        if (!req_valid[k] && $urandom_range(0, 2) == 0) begin
          req_valid[k] = 1'b1;
          dvd[k] = DW'($urandom_range(0, 36000));
        end
      step(g);
    end
    issue_en = 1'b1;
    drain();
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL random_err got=%b exp=0", err_o);
    end
    checks++;
    if (max_wait > CH_NUM - 1) begin
      errors++;
      $display("FAIL random_fairness got max_wait=%0d exp <=%0d", max_wait, CH_NUM - 1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_pair();
    test_issue_en();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
